memory_32_4_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 32-bit x 16-entry memory_32_4 array.
- Grants at most one memory command (read or write) per cycle and drives the memory's command struct and write data.
- Tracks in-flight reads through the memory's fixed 2-cycle read latency and steers returned data to the originating requester with a valid strobe.
- Sits between two client engines and a single memory_32_4 instance.

---
 rtl/memory_32_4_arbiter_pkg.sv | 35 +++
 rtl/mem_arb_rd_pipe.sv | 41 ++++
 rtl/memory_32_4_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_memory_32_4_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_32_4_arbiter_pkg.sv
// Shared types for the memory_32_4 arbiter slice.
// Defines the memory command struct, the requester count and the
// read-pipeline entry that tags in-flight reads with their requester id.
package memory_32_4_arbiter_pkg;

    localparam int MEM_DATA_W      = 32;
    localparam int MEM_ADDR_W      = 4;
    localparam int MEM_ARB_NUM_REQ = 2;
    localparam int MEM_ARB_ID_W    = 1;

    // Command bundle presented to the memory_32_4 array.
    typedef struct packed {
        logic                  wr_vld;
        logic [MEM_ADDR_W-1:0] wr_address;
        logic [MEM_ADDR_W-1:0] rd_address;
    } m_32_4;

    // One slot of the read-latency pipeline: valid flag plus originating requester.
    typedef struct packed {
        logic                    vld;
        logic [MEM_ARB_ID_W-1:0] id;
    } mem_arb_rd_entry_t;

    // Build a pipeline entry; an invalid entry always carries id 0 so bubbles are clean.
    function automatic mem_arb_rd_entry_t mem_arb_make_entry(
        input logic                    vld,
        input logic [MEM_ARB_ID_W-1:0] id
    );
        mem_arb_rd_entry_t e;
        e.vld = vld;
        e.id  = vld ? id : '0;
        return e;
    endfunction

endpackage

// File: rtl/mem_arb_rd_pipe.sv
// Fixed-depth shift register of read-pipeline entries.
// Depth equals the memory read latency so the tail lines up with the cycle
// the memory presents read data. Cleared synchronously on reset, which
// discards any reads still in flight.
module mem_arb_rd_pipe
    import memory_32_4_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  mem_arb_rd_entry_t push,
    output mem_arb_rd_entry_t tail
);

    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
            mem_arb_rd_entry_t entry_reg;
            mem_arb_rd_entry_t entry_next;

            if (gi == 0) begin : g_head
                assign entry_next = push;
            end else begin : g_body
                assign entry_next = g_stage[gi-1].entry_reg;
            end

            // Advance one stage per cycle; reset flushes the stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg <= '0;
                end else begin
                    entry_reg <= entry_next;
                end
            end
        end
    endgenerate

    assign tail = g_stage[RD_LATENCY-1].entry_reg;

endmodule

// File: rtl/memory_32_4_arbiter.sv
// Two-requester arbiter and sequencer for the shared memory_32_4 array.
// Grants at most one command per cycle, drives the memory command struct
// and write data, and steers returning read data to the requester that
// issued the read using a latency-matched tag pipeline.
//
// Build option: define MEM_ARB_FIXED_PRI_EN to give requester 0 strict
// priority (no round-robin pointer). Undefined, contention is resolved
// round-robin, with requester 0 winning the first contention after reset.
//
// RD_LATENCY must lie in 1..4 and DATA_W/ADDR_W must match the memory.
module memory_32_4_arbiter
    import memory_32_4_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    // Requester 0
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rsp_vld0,
    output logic [DATA_W-1:0] rsp_data0,
    // Requester 1
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rsp_vld1,
    output logic [DATA_W-1:0] rsp_data1,
    // Memory side
    output m_32_4             m,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] m_rd_data
);

    // Per-requester views of the inputs so the steering logic is index based.
    logic [MEM_ARB_NUM_REQ-1:0] req_vec;
    logic [MEM_ARB_NUM_REQ-1:0] gnt_vec;
    logic [MEM_ARB_NUM_REQ-1:0] rsp_vld_vec;

    assign req_vec = {req1, req0};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef MEM_ARB_FIXED_PRI_EN
    // Strict priority: requester 0 always wins; grants are suppressed in reset.
    always_comb begin
        gnt_vec = '0;
        if (!reset) begin
            if (req_vec[0]) begin
                gnt_vec = 2'b01;
            end else if (req_vec[1]) begin
                gnt_vec = 2'b10;
            end
        end
    end
`else
    // Id of the requester granted most recently; reset to 1 so requester 0
    // takes the first contention.
    logic last_gnt_reg;
    logic last_gnt_next;

    // Round-robin: under contention the requester not granted last wins.
    always_comb begin
        gnt_vec = '0;
        if (!reset) begin
            if (req_vec[0] && req_vec[1]) begin
                gnt_vec = last_gnt_reg ? 2'b01 : 2'b10;
            end else if (req_vec[0]) begin
                gnt_vec = 2'b01;
            end else if (req_vec[1]) begin
                gnt_vec = 2'b10;
            end
        end
    end

    // Move the pointer to whichever requester was granted this cycle.
    always_comb begin
        last_gnt_next = last_gnt_reg;
        if (gnt_vec[1]) begin
            last_gnt_next = 1'b1;
        end else if (gnt_vec[0]) begin
            last_gnt_next = 1'b0;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_reg <= 1'b1;
        end else begin
            last_gnt_reg <= last_gnt_next;
        end
    end
`endif

    assign gnt0 = gnt_vec[0];
    assign gnt1 = gnt_vec[1];

    // ------------------------------------------------------------------
    // Granted-command steering
    // ------------------------------------------------------------------
    logic                    any_gnt;
    logic [MEM_ARB_ID_W-1:0] gnt_id;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic                    wr_grant;
    logic                    rd_grant;

    assign any_gnt = |gnt_vec;
    assign gnt_id  = gnt_vec[1];

    // Select the granted requester's command; with no grant this falls back
    // to requester 0's inputs, which the memory ignores because wr_vld is low.
    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (gnt_vec[1]) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    assign wr_grant = any_gnt && sel_we;
    assign rd_grant = any_gnt && !sel_we;

    // ------------------------------------------------------------------
    // Memory command
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_address_reg;
    logic [ADDR_W-1:0] rd_address_next;

    // Read address only moves on a read grant; it is the first stage of the
    // memory's read latency.
    always_comb begin
        rd_address_next = rd_address_reg;
        if (rd_grant) begin
            rd_address_next = sel_addr;
        end
    end

    // Read address register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_address_reg <= '0;
        end else begin
            rd_address_reg <= rd_address_next;
        end
    end

    assign m.wr_vld     = wr_grant;
    assign m.wr_address = sel_addr;
    assign m.rd_address = rd_address_reg;
    assign m_wr_data    = sel_wdata;

    // ------------------------------------------------------------------
    // In-flight read tracking and response steering
    // ------------------------------------------------------------------
    mem_arb_rd_entry_t pipe_push;
    mem_arb_rd_entry_t pipe_tail;

    assign pipe_push = mem_arb_make_entry(rd_grant, gnt_id);

    mem_arb_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk   (clk),
        .reset (reset),
        .push  (pipe_push),
        .tail  (pipe_tail)
    );

    genvar gi;
    generate
        for (gi = 0; gi < MEM_ARB_NUM_REQ; gi++) begin : g_rsp
            // Strobe only the requester that owns the returning read; held low in reset.
            assign rsp_vld_vec[gi] = !reset && pipe_tail.vld
                                     && (pipe_tail.id == MEM_ARB_ID_W'(gi));
        end
    endgenerate

    assign rsp_vld0  = rsp_vld_vec[0];
    assign rsp_vld1  = rsp_vld_vec[1];
    assign rsp_data0 = m_rd_data;
    assign rsp_data1 = m_rd_data;

endmodule

// File: tb/tb_memory_32_4_arbiter.sv
// Self-checking bench for memory_32_4_arbiter.
// Includes a behavioural memory_32_4 (registered read of the registered
// read address), a shadow memory and a response queue as reference model.
module tb_memory_32_4_arbiter;
    import memory_32_4_arbiter_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rsp_vld0, rsp_vld1;
    logic [31:0] rsp_data0, rsp_data1;
    m_32_4       m;
    logic [31:0] m_wr_data;
    logic [31:0] m_rd_data;

    always #5 clk = ~clk;

    memory_32_4_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (4),
        .RD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rsp_vld0  (rsp_vld0),
        .rsp_data0 (rsp_data0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rsp_vld1  (rsp_vld1),
        .rsp_data1 (rsp_data1),
        .m         (m),
        .m_wr_data (m_wr_data),
        .m_rd_data (m_rd_data)
    );

    // Behavioural memory_32_4: write on wr_vld, registered read data.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (m.wr_vld) mem[m.wr_address] <= m_wr_data;
        m_rd_data <= mem[m.rd_address];
    end

    // ---------------- reference model state ----------------
    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] shadow [16];
    int          last_id;
    logic [3:0]  rd_addr_exp;
    int          cyc;

    // pending command per requester (held until granted)
    bit          p_req [2];
    bit          p_we [2];
    logic [3:0]  p_addr [2];
    logic [31:0] p_wdata [2];
    bit          rst_drv;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    task automatic apply();
        reset  = rst_drv;
        req0   = p_req[0];
        we0    = p_we[0];
        addr0  = p_addr[0];
        wdata0 = p_wdata[0];
        req1   = p_req[1];
        we1    = p_we[1];
        addr1  = p_addr[1];
        wdata1 = p_wdata[1];
    endtask

    task automatic set_cmd(input int r, input bit we, input logic [3:0] a, input logic [31:0] d);
        p_req[r]   = 1'b1;
        p_we[r]    = we;
        p_addr[r]  = a;
        p_wdata[r] = d;
    endtask

    // One clock cycle: drive, check at negedge against the model, advance model.
    task automatic step();
        int   g;
        bit   wr_exp;
        bit   ev0, ev1;
        rsp_t e;
        apply();
        @(negedge clk);
        g = -1;
        if (!rst_drv) begin
            if (p_req[0] && p_req[1]) begin
`ifdef MEM_ARB_FIXED_PRI_EN
                g = 0;
`else
                g = (last_id == 0) ? 1 : 0;
`endif
            end else if (p_req[0]) g = 0;
            else if (p_req[1]) g = 1;
        end
        check_val("gnt0", 32'(gnt0), 32'(g == 0));
        check_val("gnt1", 32'(gnt1), 32'(g == 1));
        wr_exp = (g >= 0) && p_we[g];
        check_val("wr_vld", 32'(m.wr_vld), 32'(wr_exp));
        if (wr_exp) begin
            check_val("wr_address", 32'(m.wr_address), 32'(p_addr[g]));
            check_val("wr_data", m_wr_data, p_wdata[g]);
        end
        check_val("rd_address", 32'(m.rd_address), 32'(rd_addr_exp));

        ev0 = 1'b0;
        ev1 = 1'b0;
        if (!rst_drv && rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            if (e.id == 0) begin
                ev0 = 1'b1;
                check_val("rsp_data0", rsp_data0, e.data);
            end else begin
                ev1 = 1'b1;
                check_val("rsp_data1", rsp_data1, e.data);
            end
            $display("cyc %0d: rsp r%0d data %h", cyc, e.id, e.data);
        end
        check_val("rsp_vld0", 32'(rsp_vld0), 32'(ev0));
        check_val("rsp_vld1", 32'(rsp_vld1), 32'(ev1));

        if (rst_drv) begin
            rq.delete();
            last_id     = 1;
            rd_addr_exp = '0;
        end else if (g >= 0) begin
            if (p_we[g]) begin
                shadow[p_addr[g]] = p_wdata[g];
                $display("cyc %0d: gnt r%0d wr addr %0d data %h", cyc, g, p_addr[g], p_wdata[g]);
            end else begin
                e.id   = g;
                e.data = shadow[p_addr[g]];
                e.due  = cyc + LAT;
                rq.push_back(e);
                rd_addr_exp = p_addr[g];
                $display("cyc %0d: gnt r%0d rd addr %0d", cyc, g, p_addr[g]);
            end
            last_id  = g;
            p_req[g] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        cyc         = 0;
        last_id     = 1;
        rd_addr_exp = '0;
        rst_drv     = 1'b1;
        for (int r = 0; r < 2; r++) begin
            p_req[r]   = 1'b0;
            p_we[r]    = 1'b0;
            p_addr[r]  = '0;
            p_wdata[r] = '0;
        end
        apply();
        repeat (2) @(posedge clk);
        #1;
        idle(1);            // checks reset-state outputs while reset is high
        rst_drv = 1'b0;

        // Preload every address through requester 0.
        for (int a = 0; a < 16; a++) begin
            set_cmd(0, 1'b1, 4'(a), $urandom);
            step();
        end

        // Write then read on requester 0.
        set_cmd(0, 1'b1, 4'd3, 32'hDEADBEEF);
        step();
        idle(1);
        set_cmd(0, 1'b0, 4'd3, 32'h0);
        idle(LAT + 2);

        // Continuous contention on reads of addrs 5/6.
        for (int k = 0; k < 6; k++) begin
            if (!p_req[0]) set_cmd(0, 1'b0, 4'd5, 32'h0);
            if (!p_req[1]) set_cmd(1, 1'b0, 4'd6, 32'h0);
            step();
        end
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        idle(LAT + 1);

        // Write-then-read hazard across requesters.
        set_cmd(1, 1'b1, 4'd15, 32'h12345678);
        step();
        set_cmd(0, 1'b0, 4'd15, 32'h0);
        idle(LAT + 2);

        // Reset one cycle after a read grant discards the read.
        set_cmd(0, 1'b0, 4'd5, 32'h0);
        step();
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        idle(1);

        // Mixed write/read contention right after reset.
        set_cmd(0, 1'b1, 4'd0, 32'hA5A5_0F0F);
        set_cmd(1, 1'b0, 4'd0, 32'h0);
        idle(LAT + 3);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            rst_drv = ($urandom_range(0, 99) == 0);
            for (int r = 0; r < 2; r++) begin
                if (!p_req[r] && $urandom_range(0, 3) != 0) begin
                    set_cmd(r, $urandom_range(0, 2) == 0,
                            $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                            $urandom);
                end
            end
            step();
        end
        rst_drv  = 1'b0;
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        idle(LAT + 2);
        check_val("rsp_queue_empty", 32'(rq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
